output_path_arbiter: RTL and testbench
======================================

Name: output_path_arbiter

Overview:
- Parametrised successor to the VGA/UART output selector.
- Routes frame-buffer read control from one of N_CH output sinks (VGA, UART, future Ethernet/USB) to the shared line buffer.
- Switches sinks only at frame boundaries, with a buffer-reset gap between sinks.
- Sits between the output sinks and the frame/line buffer, clocked in the single system domain.

Parameters:
N_CH, 2, number of output sinks (2..8)
SEL_W, 3, width of channel index; must satisfy 2**SEL_W >= N_CH
ROW_W, 10, width of row counter per channel
DEFAULT_CH, 0, channel selected after reset
GAP_CYCLES, 16, cycles of buffer reset between sinks (>=1)
LOW_SPEED_MASK, 2'b10, bit i set = channel i is a low-speed sink
DRAIN_TIMEOUT, 4095, max cycles waiting for frame end (optional feature only)

Ports:
CLK_50  in  1  system clock
RESET  in  1  synchronous, active-high reset
OUT_ENABLE  in  1  global output enable
MODE_REQ  in  SEL_W  requested channel index
MODE_VALID  in  1  one-cycle strobe qualifying MODE_REQ
CH_BUF_EN  in  N_CH  per-channel buffer enable
CH_BUF_CHANGE  in  N_CH  per-channel buffer swap
CH_READ_EN  in  N_CH  per-channel read enable
CH_CNT_ROW  in  N_CH*ROW_W  per-channel row counter; channel i at [i*ROW_W +: ROW_W]
CH_RESET  in  N_CH  per-channel buffer reset request
CH_FRAME_DONE  in  N_CH  per-channel end-of-frame pulse
ENABLE  out  N_CH  one-hot sink enable
BUFER_EN  out  1  muxed buffer enable
BUF_CHANGE  out  1  muxed buffer swap
READ_EN  out  1  muxed read enable
CNT_ROW  out  ROW_W  muxed row counter
BUF_RESET  out  1  buffer reset
LOW_SPEED_OUT  out  1  selected sink is low-speed
SEL_CUR  out  SEL_W  active channel index
BUSY  out  1  switch in progress
MODE_ERR  out  1  one-cycle pulse on invalid request

Behaviour:
- All outputs are registered, with 1-cycle latency from the CH_* inputs.
- Reset values:
  - ENABLE, BUFER_EN, BUF_CHANGE, READ_EN, CNT_ROW, BUSY, MODE_ERR = 0.
  - BUF_RESET = 1.
  - SEL_CUR = DEFAULT_CH.
  - LOW_SPEED_OUT = LOW_SPEED_MASK[DEFAULT_CH].
  - State = IDLE.
- States: IDLE, RUN, DRAIN, GAP.
- IDLE:
  - Mux outputs = 0, ENABLE = 0, BUF_RESET = 1.
  - OUT_ENABLE=1 -> RUN.
- RUN:
  - ENABLE[SEL_CUR] = 1.
  - BUFER_EN, BUF_CHANGE, READ_EN, CNT_ROW and BUF_RESET follow channel SEL_CUR (BUF_RESET = CH_RESET[SEL_CUR]).
  - OUT_ENABLE=0 -> IDLE.
  - Pending request != SEL_CUR -> DRAIN.
- DRAIN:
  - Same forwarding as RUN; BUSY=1.
  - CH_FRAME_DONE[SEL_CUR] -> GAP.
  - OUT_ENABLE=0 -> GAP.
  - Pending request overwritten to equal SEL_CUR -> RUN (switch aborted).
- GAP:
  - ENABLE = 0, mux outputs = 0, BUF_RESET = 1, BUSY = 1.
  - Counter runs 0..GAP_CYCLES-1.
  - On terminal count: SEL_CUR <= pending, LOW_SPEED_OUT updated, then RUN if OUT_ENABLE else IDLE.
- Request handling:
  - MODE_VALID with MODE_REQ < N_CH -> pending <= MODE_REQ; last strobe wins.
  - MODE_REQ >= N_CH -> ignored; MODE_ERR pulses 1 cycle later.
- A request accepted during GAP is held and evaluated on entry to RUN.
- A request equal to SEL_CUR in RUN is a no-op.
- A request accepted while in IDLE is applied immediately (SEL_CUR updated next cycle, no GAP).
- CH_FRAME_DONE of non-selected channels is ignored.
- CH_FRAME_DONE and a MODE_VALID strobe in the same DRAIN cycle: the FRAME_DONE transition to GAP is taken, and the new strobe is latched as pending.
- RESET mid-switch: pending is discarded and SEL_CUR returns to DEFAULT_CH.
- Gap counter width is clog2(GAP_CYCLES+1); it saturates and never wraps.
- ENABLE is never multi-hot. In any cycle at most one ENABLE bit is 1.

Optional Feature:
- Macro: OUTPUT_ARB_DRAIN_TIMEOUT_EN.
- Defined:
  - A drain counter is cleared on DRAIN entry and increments each DRAIN cycle.
  - When it reaches DRAIN_TIMEOUT, the block forces the transition to GAP and pulses MODE_ERR for 1 cycle (protects against a sink that stalls without ever signalling FRAME_DONE).
- Undefined: DRAIN waits indefinitely for CH_FRAME_DONE; no counter logic is generated.

Test Plan:
- Reset check: N_CH=2, RESET 3 cycles -> ENABLE=00, BUF_RESET=1, SEL_CUR=0, all mux outputs 0.
- Pass-through: OUT_ENABLE=1 -> RUN.
  - ENABLE=01.
  - CH_CNT_ROW ch0=10'd123 -> CNT_ROW=123 one cycle later.
  - Ch1 inputs toggling -> no effect on outputs.
- Frame-aligned switch: in RUN on ch0, MODE_REQ=1 strobe.
  - BUSY=1 and ENABLE=01 until CH_FRAME_DONE[0].
  - Then ENABLE=00, BUF_RESET=1 for exactly 16 cycles.
  - Then ENABLE=10, SEL_CUR=1, LOW_SPEED_OUT=1.
- Abort and invalid request: MODE_REQ=1 then MODE_REQ=0 during DRAIN -> back to RUN on ch0 with no GAP. MODE_REQ=5 with N_CH=2 -> MODE_ERR single pulse, state unchanged.
- Disable mid-drain: OUT_ENABLE=0 during DRAIN -> GAP for 16 cycles, SEL_CUR=1, then IDLE with ENABLE=00.
- Timeout (macro defined, DRAIN_TIMEOUT=100): request switch, never pulse FRAME_DONE -> GAP entered after 100 DRAIN cycles, MODE_ERR pulse 1 cycle.

Source files
------------

// File: rtl/output_path_arbiter.sv
// Output path arbiter: hands the shared line buffer to one of N_CH output sinks and switches only at frame ends, with a buffer-reset gap.
// Latency: every output is registered one cycle after CH_*/MODE_* inputs; a switch costs the rest of the frame plus GAP_CYCLES.
// Backpressure: none; requests are strobes (last wins), invalid ones pulse MODE_ERR. Optional drain timeout: OUTPUT_ARB_DRAIN_TIMEOUT_EN.
module output_path_arbiter #(
   parameter int                N_CH           = 2,
   parameter int                SEL_W          = 3,
   parameter int                ROW_W          = 10,
   parameter int                DEFAULT_CH     = 0,
   parameter int                GAP_CYCLES     = 16,
   parameter logic [N_CH-1:0]   LOW_SPEED_MASK = 2'b10
`ifdef OUTPUT_ARB_DRAIN_TIMEOUT_EN
   ,
   parameter int                DRAIN_TIMEOUT  = 4095
`endif
) (
   input  logic                   CLK_50,
   input  logic                   RESET,
   input  logic                   OUT_ENABLE,
   input  logic [SEL_W-1:0]       MODE_REQ,
   input  logic                   MODE_VALID,
   input  logic [N_CH-1:0]        CH_BUF_EN,
   input  logic [N_CH-1:0]        CH_BUF_CHANGE,
   input  logic [N_CH-1:0]        CH_READ_EN,
   input  logic [N_CH*ROW_W-1:0]  CH_CNT_ROW,
   input  logic [N_CH-1:0]        CH_RESET,
   input  logic [N_CH-1:0]        CH_FRAME_DONE,
   output logic [N_CH-1:0]        ENABLE,
   output logic                   BUFER_EN,
   output logic                   BUF_CHANGE,
   output logic                   READ_EN,
   output logic [ROW_W-1:0]       CNT_ROW,
   output logic                   BUF_RESET,
   output logic                   LOW_SPEED_OUT,
   output logic [SEL_W-1:0]       SEL_CUR,
   output logic                   BUSY,
   output logic                   MODE_ERR
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam int             GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

   logic [1:0]       state, state_nxt;
   logic [SEL_W-1:0] sel_cur, sel_nxt;
   logic [SEL_W-1:0] pending, pending_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
   logic             req_ok, req_bad;
   logic             gap_done;
   logic             frame_done_cur;
   logic             timeout_hit;
   logic             err_nxt;
   logic             fwd;

   logic [N_CH-1:0]  mux_onehot;
   logic             mux_buf_en, mux_buf_change, mux_read_en, mux_reset, mux_low;
   logic [ROW_W-1:0] mux_row;

   assign SEL_CUR = sel_cur;

   // Request decode: valid indices update the pending target, others only flag an error.
   always_comb begin
      req_ok      = MODE_VALID && ({1'b0, MODE_REQ} < N_CH_W);
      req_bad     = MODE_VALID && !({1'b0, MODE_REQ} < N_CH_W);
      pending_nxt = req_ok ? MODE_REQ : pending;
   end

   // End-of-frame from the currently selected sink; other sinks' pulses are ignored.
   always_comb begin
      frame_done_cur = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_cur == SEL_W'(i)) begin
            frame_done_cur = CH_FRAME_DONE[i];
         end
      end
   end

`ifdef OUTPUT_ARB_DRAIN_TIMEOUT_EN
   localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
   logic [DRAIN_W-1:0] drain_cnt;

   // Drain watchdog: counts DRAIN cycles, reads zero on the first cycle of every DRAIN visit.
   always_ff @(posedge CLK_50) begin
      if (RESET || (state != ST_DRAIN)) begin
         drain_cnt <= '0;
      end else if (drain_cnt != DRAIN_W'(DRAIN_TIMEOUT)) begin
         drain_cnt <= drain_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state == ST_DRAIN) && (drain_cnt == DRAIN_W'(DRAIN_TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   assign gap_done = (state == ST_GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

   // Sequencing: idle, forward a sink, drain to its frame end, then hold the buffer in reset for the gap.
   always_comb begin
      state_nxt   = state;
      sel_nxt     = sel_cur;
      gap_cnt_nxt = '0;
      case (state)
         ST_IDLE: begin
            // Buffer is already held in reset, so a new target takes effect at once.
            sel_nxt = pending_nxt;
            if (OUT_ENABLE) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!OUT_ENABLE) begin
               state_nxt = ST_IDLE;
            end else if (pending != sel_cur) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (frame_done_cur || !OUT_ENABLE || timeout_hit) begin
               state_nxt = ST_GAP;
            end else if (pending == sel_cur) begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            if (gap_cnt != GAP_W'(GAP_CYCLES)) begin
               gap_cnt_nxt = gap_cnt + 1'b1;
            end else begin
               gap_cnt_nxt = gap_cnt;
            end
            if (gap_done) begin
               sel_nxt   = pending;
               state_nxt = OUT_ENABLE ? ST_RUN : ST_IDLE;
            end
         end
      endcase
      err_nxt = req_bad || (timeout_hit && !frame_done_cur);
   end

   // Channel mux keyed on the channel that will be live after this edge.
   always_comb begin
      mux_onehot     = '0;
      mux_buf_en     = 1'b0;
      mux_buf_change = 1'b0;
      mux_read_en    = 1'b0;
      mux_row        = '0;
      mux_reset      = 1'b1;
      mux_low        = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_nxt == SEL_W'(i)) begin
            mux_onehot[i]  = 1'b1;
            mux_buf_en     = CH_BUF_EN[i];
            mux_buf_change = CH_BUF_CHANGE[i];
            mux_read_en    = CH_READ_EN[i];
            mux_row        = CH_CNT_ROW[i*ROW_W +: ROW_W];
            mux_reset      = CH_RESET[i];
            mux_low        = LOW_SPEED_MASK[i];
         end
      end
      fwd = (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
   end

   // State and registered outputs; outputs always describe the state being entered.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         state         <= ST_IDLE;
         sel_cur       <= SEL_W'(DEFAULT_CH);
         pending       <= SEL_W'(DEFAULT_CH);
         gap_cnt       <= '0;
         ENABLE        <= '0;
         BUFER_EN      <= 1'b0;
         BUF_CHANGE    <= 1'b0;
         READ_EN       <= 1'b0;
         CNT_ROW       <= '0;
         BUF_RESET     <= 1'b1;
         LOW_SPEED_OUT <= LOW_SPEED_MASK[DEFAULT_CH];
         BUSY          <= 1'b0;
         MODE_ERR      <= 1'b0;
      end else begin
         state         <= state_nxt;
         sel_cur       <= sel_nxt;
         pending       <= pending_nxt;
         gap_cnt       <= gap_cnt_nxt;
         ENABLE        <= fwd ? mux_onehot : '0;
         BUFER_EN      <= fwd && mux_buf_en;
         BUF_CHANGE    <= fwd && mux_buf_change;
         READ_EN       <= fwd && mux_read_en;
         CNT_ROW       <= fwd ? mux_row : '0;
         BUF_RESET     <= fwd ? mux_reset : 1'b1;
         LOW_SPEED_OUT <= mux_low;
         BUSY          <= (state_nxt == ST_DRAIN) || (state_nxt == ST_GAP);
         MODE_ERR      <= err_nxt;
      end
   end

endmodule

// File: tb/tb_output_path_arbiter.sv
// Bench for output_path_arbiter: directed frame-switch scenarios plus randomized traffic.
// Latency: outputs checked every cycle against a behavioural model updated on the same edge as the DUT.
// Backpressure: not applicable; all stimulus is strobe/level driven.
module tb_output_path_arbiter;
   localparam int         N_CH    = 2;
   localparam int         SEL_W   = 3;
   localparam int         ROW_W   = 10;
   localparam int         GAP     = 16;
   localparam logic [1:0] LS_MASK = 2'b10;
`ifdef OUTPUT_ARB_DRAIN_TIMEOUT_EN
   localparam int         DT      = 100;
`endif
   localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_GAP = 3;

   logic                  CLK_50 = 1'b0;
   logic                  RESET = 1'b1;
   logic                  OUT_ENABLE = 1'b0;
   logic [SEL_W-1:0]      MODE_REQ = '0;
   logic                  MODE_VALID = 1'b0;
   logic [N_CH-1:0]       CH_BUF_EN = '0;
   logic [N_CH-1:0]       CH_BUF_CHANGE = '0;
   logic [N_CH-1:0]       CH_READ_EN = '0;
   logic [N_CH*ROW_W-1:0] CH_CNT_ROW = '0;
   logic [N_CH-1:0]       CH_RESET = '0;
   logic [N_CH-1:0]       CH_FRAME_DONE = '0;
   logic [N_CH-1:0]       ENABLE;
   logic                  BUFER_EN, BUF_CHANGE, READ_EN, BUF_RESET, LOW_SPEED_OUT, BUSY, MODE_ERR;
   logic [ROW_W-1:0]      CNT_ROW;
   logic [SEL_W-1:0]      SEL_CUR;

   int checks = 0;
   int failures = 0;

   output_path_arbiter #(
      .N_CH(N_CH), .SEL_W(SEL_W), .ROW_W(ROW_W), .DEFAULT_CH(0),
      .GAP_CYCLES(GAP), .LOW_SPEED_MASK(LS_MASK)
`ifdef OUTPUT_ARB_DRAIN_TIMEOUT_EN
      , .DRAIN_TIMEOUT(DT)
`endif
   ) dut (
      .CLK_50(CLK_50), .RESET(RESET), .OUT_ENABLE(OUT_ENABLE),
      .MODE_REQ(MODE_REQ), .MODE_VALID(MODE_VALID),
      .CH_BUF_EN(CH_BUF_EN), .CH_BUF_CHANGE(CH_BUF_CHANGE), .CH_READ_EN(CH_READ_EN),
      .CH_CNT_ROW(CH_CNT_ROW), .CH_RESET(CH_RESET), .CH_FRAME_DONE(CH_FRAME_DONE),
      .ENABLE(ENABLE), .BUFER_EN(BUFER_EN), .BUF_CHANGE(BUF_CHANGE), .READ_EN(READ_EN),
      .CNT_ROW(CNT_ROW), .BUF_RESET(BUF_RESET), .LOW_SPEED_OUT(LOW_SPEED_OUT),
      .SEL_CUR(SEL_CUR), .BUSY(BUSY), .MODE_ERR(MODE_ERR)
   );

   always #5 CLK_50 = ~CLK_50;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks which sink owns the buffer, the wanted sink, and how many gap cycles remain.
   int  m_st, m_sel, m_pend, m_gap_left, m_drain, np;
   bit  m_ok = 1'b0;
   bit  live;
   logic [N_CH-1:0]  e_enable;
   logic             e_bufen, e_chg, e_rd, e_bufrst, e_low, e_busy, e_err;
   logic [ROW_W-1:0] e_row;

   always @(posedge CLK_50) begin
      if (RESET) begin
         m_st = S_IDLE; m_sel = 0; m_pend = 0; m_gap_left = 0; m_drain = 0; e_err = 1'b0;
      end else begin
         e_err = 1'b0;
         np = m_pend;
         if (MODE_VALID) begin
            if (int'(MODE_REQ) < N_CH) np = int'(MODE_REQ);
            else e_err = 1'b1;
         end
         case (m_st)
            S_IDLE: begin
               m_sel = np;
               if (OUT_ENABLE) m_st = S_RUN;
            end
            S_RUN: begin
               if (!OUT_ENABLE) m_st = S_IDLE;
               else if (m_pend != m_sel) begin m_st = S_DRAIN; m_drain = 0; end
            end
            S_DRAIN: begin
               m_drain++;
               if (1'(CH_FRAME_DONE >> m_sel)) begin m_st = S_GAP; m_gap_left = GAP; end
`ifdef OUTPUT_ARB_DRAIN_TIMEOUT_EN
               else if (m_drain == DT) begin m_st = S_GAP; m_gap_left = GAP; e_err = 1'b1; end
`endif
               else if (!OUT_ENABLE) begin m_st = S_GAP; m_gap_left = GAP; end
               else if (m_pend == m_sel) m_st = S_RUN;
            end
            default: begin
               m_gap_left--;
               if (m_gap_left == 0) begin
                  m_sel = m_pend;
                  m_st  = OUT_ENABLE ? S_RUN : S_IDLE;
               end
            end
         endcase
         m_pend = np;
      end
      live     = (m_st == S_RUN) || (m_st == S_DRAIN);
      e_enable = live ? N_CH'(1 << m_sel) : '0;
      e_bufen  = live && 1'(CH_BUF_EN >> m_sel);
      e_chg    = live && 1'(CH_BUF_CHANGE >> m_sel);
      e_rd     = live && 1'(CH_READ_EN >> m_sel);
      e_row    = live ? ROW_W'(CH_CNT_ROW >> (m_sel * ROW_W)) : '0;
      e_bufrst = live ? 1'(CH_RESET >> m_sel) : 1'b1;
      e_low    = 1'(LS_MASK >> m_sel);
      e_busy   = (m_st == S_DRAIN) || (m_st == S_GAP);
      m_ok     = 1'b1;
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge CLK_50) begin
      if (m_ok) begin
         chk("enable",     32'(ENABLE),        32'(e_enable));
         chk("bufer_en",   32'(BUFER_EN),      32'(e_bufen));
         chk("buf_change", 32'(BUF_CHANGE),    32'(e_chg));
         chk("read_en",    32'(READ_EN),       32'(e_rd));
         chk("cnt_row",    32'(CNT_ROW),       32'(e_row));
         chk("buf_reset",  32'(BUF_RESET),     32'(e_bufrst));
         chk("low_speed",  32'(LOW_SPEED_OUT), 32'(e_low));
         chk("sel_cur",    32'(SEL_CUR),       32'(m_sel));
         chk("busy",       32'(BUSY),          32'(e_busy));
         chk("mode_err",   32'(MODE_ERR),      32'(e_err));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLK_50);
      #2;
   endtask

   task automatic strobe(input logic [SEL_W-1:0] req);
      MODE_REQ   = req;
      MODE_VALID = 1'b1;
      tick();
      MODE_VALID = 1'b0;
   endtask

   int gap_n, errs, g;

   initial begin
      // Reset
      RESET = 1'b1;
      repeat (3) tick();
      chk("rst_enable",    32'(ENABLE),    32'h0);
      chk("rst_buf_reset", 32'(BUF_RESET), 32'h1);
      chk("rst_sel_cur",   32'(SEL_CUR),   32'h0);
      chk("rst_cnt_row",   32'(CNT_ROW),   32'h0);
      chk("rst_busy",      32'(BUSY),      32'h0);
      RESET = 1'b0;

      // Pass-through on channel 0
      OUT_ENABLE = 1'b1;
      CH_CNT_ROW[0 +: ROW_W] = 10'd123;
      tick();
      chk("pt_enable",  32'(ENABLE),  32'h1);
      chk("pt_cnt_row", 32'(CNT_ROW), 32'd123);
      CH_CNT_ROW[ROW_W +: ROW_W] = 10'd777;
      CH_BUF_EN  = 2'b10;
      CH_RESET   = 2'b10;
      CH_READ_EN = 2'b10;
      tick();
      chk("pt_ch1_row",   32'(CNT_ROW),   32'd123);
      chk("pt_ch1_rst",   32'(BUF_RESET), 32'h0);
      chk("pt_ch1_bufen", 32'(BUFER_EN),  32'h0);
      CH_BUF_EN = '0; CH_RESET = '0; CH_READ_EN = '0;

      // Frame-aligned switch 0 -> 1
      strobe(3'd1);
      tick();
      chk("sw_busy",   32'(BUSY),   32'h1);
      chk("sw_enable", 32'(ENABLE), 32'h1);
      CH_FRAME_DONE = 2'b10;
      tick();
      CH_FRAME_DONE = 2'b00;
      chk("sw_other_fd_busy", 32'(BUSY),   32'h1);
      chk("sw_other_fd_en",   32'(ENABLE), 32'h1);
      CH_FRAME_DONE = 2'b01;
      tick();
      CH_FRAME_DONE = 2'b00;
      gap_n = 0;
      g = 0;
      while (ENABLE == '0 && g < 40) begin
         if (BUF_RESET && BUSY) gap_n++;
         tick();
         g++;
      end
      chk("sw_gap_len",   32'(gap_n),         32'd16);
      chk("sw_enable_1",  32'(ENABLE),        32'h2);
      chk("sw_sel_cur",   32'(SEL_CUR),       32'h1);
      chk("sw_low_speed", 32'(LOW_SPEED_OUT), 32'h1);

      // Abort: request 0 then back to 1 while draining
      strobe(3'd0);
      tick();
      chk("ab_busy", 32'(BUSY), 32'h1);
      strobe(3'd1);
      chk("ab_still_en", 32'(ENABLE), 32'h2);
      tick();
      chk("ab_busy_clr", 32'(BUSY),    32'h0);
      chk("ab_enable",   32'(ENABLE),  32'h2);
      chk("ab_sel_cur",  32'(SEL_CUR), 32'h1);

      // Invalid request
      strobe(3'd5);
      chk("inv_err", 32'(MODE_ERR), 32'h1);
      errs = 0;
      repeat (4) begin
         tick();
         errs += int'(MODE_ERR);
      end
      chk("inv_err_once", 32'(errs),    32'h0);
      chk("inv_sel_cur",  32'(SEL_CUR), 32'h1);
      chk("inv_busy",     32'(BUSY),    32'h0);

      // Disable mid-drain: switch completes through the gap into IDLE
      strobe(3'd0);
      tick();
      OUT_ENABLE = 1'b0;
      tick();
      gap_n = 0;
      g = 0;
      while (BUSY && g < 40) begin
         if (ENABLE == '0 && BUF_RESET) gap_n++;
         tick();
         g++;
      end
      chk("dis_gap_len",   32'(gap_n),         32'd16);
      chk("dis_enable",    32'(ENABLE),        32'h0);
      chk("dis_sel_cur",   32'(SEL_CUR),       32'h0);
      chk("dis_low_speed", 32'(LOW_SPEED_OUT), 32'h0);
      chk("dis_buf_reset", 32'(BUF_RESET),     32'h1);

      // Stalled sink: switch requested, FRAME_DONE never arrives
      RESET = 1'b1;
      repeat (2) tick();
      RESET = 1'b0;
      OUT_ENABLE = 1'b1;
      tick();
      strobe(3'd1);
      for (int i = 0; i < 150; i++) begin
         CH_BUF_EN  = N_CH'($urandom);
         CH_READ_EN = N_CH'($urandom);
         CH_CNT_ROW = (N_CH*ROW_W)'($urandom);
         tick();
      end

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         RESET         = ($urandom_range(0, 999) < 3);
         OUT_ENABLE    = ($urandom_range(0, 99) < 92);
         MODE_VALID    = ($urandom_range(0, 99) < 6);
         MODE_REQ      = SEL_W'($urandom_range(0, 7));
         CH_BUF_EN     = N_CH'($urandom);
         CH_BUF_CHANGE = N_CH'($urandom);
         CH_READ_EN    = N_CH'($urandom);
         CH_RESET      = N_CH'($urandom);
         CH_CNT_ROW    = (N_CH*ROW_W)'($urandom);
         CH_FRAME_DONE = {($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 8)};
         tick();
      end

      MODE_VALID = 1'b0;
      @(negedge CLK_50);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
